fpu_split_initiator: RTL

- Initiator-side bridge for the team's 16-bit split stb/ack FPU core interface (divider, and future adder/multiplier cores sharing the same port shape).
- Accepts one 32-bit operand pair (a, b) on a wide command port.
- Serialises the pair as a-hi, a-lo, b-hi, b-lo over the core's 16-bit input channels, then collects z-hi and z-lo.
- Presents the reassembled 32-bit result on a wide response port.
- Sits between a CPU or stream wrapper and any single split-word FPU core.

---
 rtl/fpu_if_pkg.sv | 21 ++
 rtl/fpu_split_initiator_if.sv | 44 ++++
 rtl/fpu_half_tx.sv | 33 +++
 rtl/fpu_split_initiator.sv | 131 +++++++++++++
 4 files changed

// File: rtl/fpu_if_pkg.sv
// Shared types and constants for the split-word FPU initiator.
package fpu_if_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

  // Result reported when the core never answers.
  localparam logic [WORD_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    StIdle,
    StSendAHi,
    StSendALo,
    StSendBHi,
    StSendBLo,
    StRecvZHi,
    StRecvZLo,
    StResp
  } state_e;

endpackage

// File: rtl/fpu_split_initiator_if.sv
// Wide command/response ports plus the 16-bit split stb/ack core channels.
interface fpu_split_initiator_if;
  import fpu_if_pkg::*;

  // Wide command side
  logic [WORD_W-1:0] cmd_a;
  logic [WORD_W-1:0] cmd_b;
  logic              cmd_stb;
  logic              cmd_ack;

  // Wide response side
  logic [WORD_W-1:0] res_z;
  logic              res_err;
  logic              res_stb;
  logic              res_ack;

  // Split-word core channels
  logic [HALF_W-1:0] fpu_a;
  logic              fpu_a_stb;
  logic              fpu_a_ack;
  logic [HALF_W-1:0] fpu_b;
  logic              fpu_b_stb;
  logic              fpu_b_ack;
  logic [HALF_W-1:0] fpu_z;
  logic              fpu_z_stb;
  logic              fpu_z_ack;

  // The initiator block
  modport master (
    input  cmd_a, cmd_b, cmd_stb, res_ack,
    input  fpu_a_ack, fpu_b_ack, fpu_z, fpu_z_stb,
    output cmd_ack, res_z, res_err, res_stb,
    output fpu_a, fpu_a_stb, fpu_b, fpu_b_stb, fpu_z_ack
  );

  // The surroundings: CPU/stream wrapper on one side, the core on the other
  modport slave (
    output cmd_a, cmd_b, cmd_stb, res_ack,
    output fpu_a_ack, fpu_b_ack, fpu_z, fpu_z_stb,
    input  cmd_ack, res_z, res_err, res_stb,
    input  fpu_a, fpu_a_stb, fpu_b, fpu_b_stb, fpu_z_ack
  );

endinterface

// File: rtl/fpu_half_tx.sv
// Serialises a 32-bit word onto one 16-bit stb/ack channel, one half at a time.
// While start is held, the half picked by sel_lo is offered; done pulses on
// the edge that transfers it. stb drops for one cycle after every transfer.
module fpu_half_tx
  import fpu_if_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sel_lo,
  input  logic [WORD_W-1:0] word,
  output logic [HALF_W-1:0] data,
  output logic              stb,
  input  logic              ack,
  output logic              done
);

  assign done = stb & ack;

  // Registered stb/data: raise when enabled, drop after each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb  <= 1'b0;
      data <= '0;
    end else if (!start || done) begin
      stb <= 1'b0;
    end else begin
      stb  <= 1'b1;
      data <= sel_lo ? word[HALF_W-1:0] : word[WORD_W-1:HALF_W];
    end
  end

endmodule

// File: rtl/fpu_split_initiator.sv
// Initiator bridge: wide (a, b) command in, four half-words out to a split-word
// FPU core, two half-words back, reassembled 32-bit result out.
module fpu_split_initiator
  import fpu_if_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 0,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fpu_split_initiator_if.master bus,
  output logic                 busy
);

  // Counter value on the last waiting cycle before the timeout fires.
  localparam logic [TIMEOUT_W-1:0] TmoLast =
    (TIMEOUT == 0) ? '0 : TIMEOUT_W'(TIMEOUT - 1);

  state_e                state_q;
  logic [WORD_W-1:0]     a_q;
  logic [WORD_W-1:0]     b_q;
  logic [TIMEOUT_W-1:0]  tmo_q;

  logic a_start, a_lo, a_done;
  logic b_start, b_lo, b_done;
  logic z_xfer;

  assign a_start = (state_q == StSendAHi) || (state_q == StSendALo);
  assign a_lo    = (state_q == StSendALo);
  assign b_start = (state_q == StSendBHi) || (state_q == StSendBLo);
  assign b_lo    = (state_q == StSendBLo);
  assign z_xfer  = bus.fpu_z_stb & bus.fpu_z_ack;
  assign busy    = (state_q != StIdle);

  fpu_half_tx u_tx_a (
    .clk    (clk),
    .rst    (rst),
    .start  (a_start),
    .sel_lo (a_lo),
    .word   (a_q),
    .data   (bus.fpu_a),
    .stb    (bus.fpu_a_stb),
    .ack    (bus.fpu_a_ack),
    .done   (a_done)
  );

  fpu_half_tx u_tx_b (
    .clk    (clk),
    .rst    (rst),
    .start  (b_start),
    .sel_lo (b_lo),
    .word   (b_q),
    .data   (bus.fpu_b),
    .stb    (bus.fpu_b_stb),
    .ack    (bus.fpu_b_ack),
    .done   (b_done)
  );

  // Sequencing FSM; owns command accept, result receive and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      a_q           <= '0;
      b_q           <= '0;
      tmo_q         <= '0;
      bus.cmd_ack   <= 1'b0;
      bus.res_stb   <= 1'b0;
      bus.res_err   <= 1'b0;
      bus.res_z     <= '0;
      bus.fpu_z_ack <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_stb && bus.cmd_ack) begin
            a_q         <= bus.cmd_a;
            b_q         <= bus.cmd_b;
            bus.cmd_ack <= 1'b0;
            state_q     <= StSendAHi;
          end else begin
            bus.cmd_ack <= 1'b1;
          end
        end
        StSendAHi: if (a_done) state_q <= StSendALo;
        StSendALo: if (a_done) state_q <= StSendBHi;
        StSendBHi: if (b_done) state_q <= StSendBLo;
        StSendBLo: begin
          if (b_done) begin
            tmo_q   <= '0;
            state_q <= StRecvZHi;
          end
        end
        StRecvZHi: begin
          // A transfer on the same edge as the timeout takes priority.
          if (z_xfer) begin
            bus.res_z[WORD_W-1:HALF_W] <= bus.fpu_z;
            bus.fpu_z_ack              <= 1'b0;
            state_q                    <= StRecvZLo;
          end else if ((TIMEOUT != 0) && (tmo_q == TmoLast)) begin
            bus.res_z     <= QNAN;
            bus.res_err   <= 1'b1;
            bus.fpu_z_ack <= 1'b0;
            state_q       <= StResp;
          end else begin
            bus.fpu_z_ack <= 1'b1;
            tmo_q         <= tmo_q + 1'b1;
          end
        end
        StRecvZLo: begin
          if (z_xfer) begin
            bus.res_z[HALF_W-1:0] <= bus.fpu_z;
            bus.res_err           <= 1'b0;
            bus.fpu_z_ack         <= 1'b0;
            state_q               <= StResp;
          end else begin
            bus.fpu_z_ack <= 1'b1;
          end
        end
        StResp: begin
          if (bus.res_stb && bus.res_ack) begin
            bus.res_stb <= 1'b0;
            state_q     <= StIdle;
          end else begin
            bus.res_stb <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
